// File: rtl/key_pkg.sv
// Shared definitions for the synthetic key driver: FSM state codes and the
// electrical sense of a pressed key.
package key_pkg;

    // Dense 2-bit encoding; every code is a legal state.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PRESS   = 2'b01,
        RELEASE = 2'b10,
        DONE    = 2'b11
    } key_state_e;

    // A pressed pushbutton pulls its line low.
    localparam logic KEY_ACTIVE = 1'b0;

endpackage : key_pkg

// File: rtl/cycle_timer.sv
// Loadable down-counter used to time the press and gap phases.
// load has priority over dec; dec at zero holds the value (never wraps).
module cycle_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               dec,
    output logic [TIMER_W-1:0] value,
    output logic               zero
);

    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;

    // Next timer value: reload, count down, or hold.
    always_comb begin
        timer_d = timer_q;
        if (load) begin
            timer_d = load_value;
        end else if (dec && (timer_q != '0)) begin
            timer_d = timer_q - TIMER_W'(1);
        end
    end

    // Timer register, cleared asynchronously on active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign value = timer_q;
    assign zero  = (timer_q == '0);

endmodule : cycle_timer

// File: rtl/key_press_driver.sv
// Synthesizes an active-low pushbutton waveform: a burst of press_count
// press/release cycles per accepted start, followed by a one-cycle done.
//
// Request handshake: start is a one-cycle request with no back-pressure.
// It is accepted only in IDLE (busy == 0); press_count is captured in that
// same cycle. A start seen while busy (PRESS, RELEASE or DONE) is dropped,
// not queued.
module key_press_driver
    import key_pkg::*;
#(
    parameter int PRESS_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int TIMER_W      = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] press_count,
    output logic       key_out,
    output logic       busy,
    output logic       done
);

    localparam logic [TIMER_W-1:0] PRESS_LOAD = TIMER_W'(PRESS_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);

    key_state_e         state_q;
    key_state_e         state_d;
    logic [7:0]         remaining_q;
    logic [7:0]         remaining_d;

    logic               timer_load;
    logic [TIMER_W-1:0] timer_load_value;
    logic               timer_dec;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_zero;

    cycle_timer #(
        .TIMER_W (TIMER_W)
    ) u_cycle_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_load_value),
        .dec        (timer_dec),
        .value      (timer_value),
        .zero       (timer_zero)
    );

    // Next-state logic, timer control and press bookkeeping.
    always_comb begin
        state_d          = state_q;
        remaining_d      = remaining_q;
        timer_load       = 1'b0;
        timer_load_value = PRESS_LOAD;
        timer_dec        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (press_count != 8'd0) begin
                        state_d          = PRESS;
                        timer_load       = 1'b1;
                        timer_load_value = PRESS_LOAD;
                        remaining_d      = press_count;
                    end else begin
                        // Empty burst: no press, but completion still reported.
                        state_d = DONE;
                    end
                end
            end
            PRESS: begin
                if (timer_zero) begin
                    state_d          = RELEASE;
                    timer_load       = 1'b1;
                    timer_load_value = GAP_LOAD;
                    if (remaining_q != 8'd0) begin
                        remaining_d = remaining_q - 8'd1;
                    end
                end else begin
                    timer_dec = 1'b1;
                end
            end
            RELEASE: begin
                if (timer_zero) begin
                    if (remaining_q != 8'd0) begin
                        state_d          = PRESS;
                        timer_load       = 1'b1;
                        timer_load_value = PRESS_LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    timer_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and press-count registers, cleared asynchronously on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    // Moore outputs decoded from state alone, so reset forces them at once.
    assign key_out = (state_q == PRESS) ? KEY_ACTIVE : ~KEY_ACTIVE;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule : key_press_driver

// File: tb/tb_key_press_driver.sv
// Directed bench for key_press_driver. Cycle k is the k-th clock period after
// the edge that samples start (edge 0); outputs are sampled on the falling edge.
module tb_key_press_driver;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] press_count;
    logic       key_out;
    logic       busy;
    logic       done;

    logic       start_f;
    logic [7:0] press_count_f;
    logic       key_out_f;
    logic       busy_f;
    logic       done_f;

    int n_cmp;
    int n_err;

    key_press_driver #(
        .PRESS_CYCLES (4),
        .GAP_CYCLES   (4),
        .TIMER_W      (16)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .press_count (press_count),
        .key_out     (key_out),
        .busy        (busy),
        .done        (done)
    );

    key_press_driver #(
        .PRESS_CYCLES (1),
        .GAP_CYCLES   (1),
        .TIMER_W      (4)
    ) u_fast (
        .clock       (clock),
        .reset       (reset),
        .start       (start_f),
        .press_count (press_count_f),
        .key_out     (key_out_f),
        .busy        (busy_f),
        .done        (done_f)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        press_count = 8'd0;
        start_f = 1'b0;
        press_count_f = 8'd0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({key_out, busy, done} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_held: key_out/busy/done=%b expected 100", {key_out, busy, done});
        end
        reset = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            n_cmp++;
            if ({key_out, busy, done} !== 3'b100) begin
                n_err++;
                $display("FAIL reset_idle cycle %0d: key_out/busy/done=%b expected 100", k, {key_out, busy, done});
            end
        end
    endtask

    task automatic test_single_press();
        logic exp_key;
        logic exp_busy;
        logic exp_done;
        @(negedge clock);
        start = 1'b1;
        press_count = 8'd1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            start = 1'b0;
            exp_key  = !(k >= 1 && k <= 4);
            exp_busy = (k >= 1 && k <= 9);
            exp_done = (k == 9);
            n_cmp++;
            if ({key_out, busy, done} !== {exp_key, exp_busy, exp_done}) begin
                n_err++;
                $display("FAIL single_press cycle %0d: key_out/busy/done=%b expected %b",
                         k, {key_out, busy, done}, {exp_key, exp_busy, exp_done});
            end
        end
    endtask

    task automatic test_loopback();
        logic prev_key;
        int   low_run;
        int   releases;
        int   done_cnt;
        int   done_cyc;
        prev_key = 1'b1;
        low_run  = 0;
        releases = 0;
        done_cnt = 0;
        done_cyc = -1;
        @(negedge clock);
        start = 1'b1;
        press_count = 8'd3;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clock);
            start = 1'b0;
            press_count = 8'd9;
            if (key_out === 1'b0) low_run++;
            if (prev_key === 1'b0 && key_out === 1'b1) begin
                releases++;
                n_cmp++;
                if (low_run != 4) begin
                    n_err++;
                    $display("FAIL loopback_press_width release %0d: low for %0d cycles expected 4", releases, low_run);
                end
                low_run = 0;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            prev_key = key_out;
        end
        n_cmp++;
        if (releases != 3) begin
            n_err++;
            $display("FAIL loopback_pulses: detector pulses=%0d expected 3", releases);
        end
        n_cmp++;
        if (done_cyc != 25 || done_cnt != 1) begin
            n_err++;
            $display("FAIL loopback_done: first done cycle=%0d count=%0d expected cycle 25 count 1", done_cyc, done_cnt);
        end
    endtask

    task automatic test_zero_count();
        int lows;
        lows = 0;
        @(negedge clock);
        start = 1'b1;
        press_count = 8'd0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (key_out !== 1'b1) lows++;
            if (k == 1) begin
                n_cmp++;
                if ({busy, done} !== 2'b11) begin
                    n_err++;
                    $display("FAIL zero_count_done: busy/done=%b expected 11", {busy, done});
                end
            end
            if (k == 2) begin
                n_cmp++;
                if ({busy, done} !== 2'b00) begin
                    n_err++;
                    $display("FAIL zero_count_after: busy/done=%b expected 00", {busy, done});
                end
            end
        end
        n_cmp++;
        if (lows != 0) begin
            n_err++;
            $display("FAIL zero_count_key: key_out low for %0d cycles expected 0", lows);
        end
    endtask

    task automatic test_ignored_start();
        int lows;
        int done_cnt;
        int done_cyc;
        lows = 0;
        done_cnt = 0;
        done_cyc = -1;
        @(negedge clock);
        start = 1'b1;
        press_count = 8'd2;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            if (key_out === 1'b0) lows++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            // A retrigger mid-burst and one during the DONE cycle.
            start = (k == 6 || k == 17);
            press_count = 8'd7;
        end
        start = 1'b0;
        n_cmp++;
        if (lows != 8) begin
            n_err++;
            $display("FAIL ignored_start_len: low cycles=%0d expected 8", lows);
        end
        n_cmp++;
        if (done_cnt != 1 || done_cyc != 17) begin
            n_err++;
            $display("FAIL ignored_start_done: done count=%0d first cycle=%0d expected 1 at 17", done_cnt, done_cyc);
        end
    endtask

    task automatic test_reset_mid_burst();
        int active;
        int done_cyc;
        active = 0;
        done_cyc = -1;
        @(negedge clock);
        start = 1'b1;
        press_count = 8'd5;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            start = 1'b0;
        end
        n_cmp++;
        if (key_out !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_burst_pre: key_out/busy=%b expected 01", {key_out, busy});
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({key_out, busy, done} !== 3'b100) begin
            n_err++;
            $display("FAIL mid_burst_async: key_out/busy/done=%b expected 100", {key_out, busy, done});
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if ({key_out, busy, done} !== 3'b100) active++;
        end
        n_cmp++;
        if (active != 0) begin
            n_err++;
            $display("FAIL mid_burst_idle: non-idle cycles=%0d expected 0", active);
        end
        start = 1'b1;
        press_count = 8'd1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (done === 1'b1 && done_cyc < 0) done_cyc = k;
        end
        n_cmp++;
        if (done_cyc != 9) begin
            n_err++;
            $display("FAIL mid_burst_restart: done cycle=%0d expected 9", done_cyc);
        end
    endtask

    task automatic test_max_count();
        int falls;
        int bad_pattern;
        int done_cnt;
        int done_cyc;
        logic prev_key;
        logic exp_key;
        falls = 0;
        bad_pattern = 0;
        done_cnt = 0;
        done_cyc = -1;
        prev_key = 1'b1;
        @(negedge clock);
        start_f = 1'b1;
        press_count_f = 8'd255;
        for (int k = 1; k <= 520; k++) begin
            @(negedge clock);
            start_f = 1'b0;
            if (k == 100) press_count_f = 8'd3;
            exp_key = !((k <= 509) && (k % 2 == 1));
            if (key_out_f !== exp_key) bad_pattern++;
            if (prev_key === 1'b1 && key_out_f === 1'b0) falls++;
            if (done_f === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (k == 510) begin
                n_cmp++;
                if (busy_f !== 1'b1) begin
                    n_err++;
                    $display("FAIL max_count_busy: busy=%b at cycle 510 expected 1", busy_f);
                end
            end
            if (k == 512) begin
                n_cmp++;
                if (busy_f !== 1'b0) begin
                    n_err++;
                    $display("FAIL max_count_idle: busy=%b at cycle 512 expected 0", busy_f);
                end
            end
            prev_key = key_out_f;
        end
        n_cmp++;
        if (falls != 255) begin
            n_err++;
            $display("FAIL max_count_pulses: low pulses=%0d expected 255", falls);
        end
        n_cmp++;
        if (bad_pattern != 0) begin
            n_err++;
            $display("FAIL max_count_pattern: %0d cycles off the expected key_out pattern, expected 0", bad_pattern);
        end
        n_cmp++;
        if (done_cnt != 1 || done_cyc != 511) begin
            n_err++;
            $display("FAIL max_count_done: done count=%0d first cycle=%0d expected 1 at 511", done_cnt, done_cyc);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_press();
        test_loopback();
        test_zero_count();
        test_ignored_start();
        test_reset_mid_burst();
        test_max_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_key_press_driver

// File: doc/key_press_driver.md
Name: key_press_driver

Overview:
- Transmit-side counterpart of the keypressed detector. Synthesizes a pushbutton-style active-low waveform on key_out: a burst of press_count press/release cycles, one burst per start request.
- Used for self-test and automation. key_out drives the enable_in of keypressed, either in place of KEY1 or muxed with it.
- Every completed press/release cycle must produce exactly one enable_out pulse at the detector.

Parameters:
- PRESS_CYCLES, 4: clock cycles key_out is held low per press; legal range >=1.
- GAP_CYCLES, 4: clock cycles key_out is held high after each press; legal range >=1.
- TIMER_W, 16: width of the internal phase timer; must satisfy 2^TIMER_W > max(PRESS_CYCLES, GAP_CYCLES).

Ports:
- clock  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low (connect to KEY0).
- start  input  1  one-cycle request pulse, e.g. the keypressed enable_out of another button.
- press_count  input  8  number of presses in the burst; sampled only on an accepted start.
- key_out  output  1  synthetic button level, active-low; idle 1.
- busy  output  1  high while a burst is in progress, including the DONE cycle.
- done  output  1  one-cycle pulse marking burst completion.

Behaviour:
- States, 2-bit dense encoding: IDLE=00, PRESS=01, RELEASE=10, DONE=11.
- Registers: state, timer[TIMER_W-1:0], remaining[7:0]. All are cleared asynchronously on reset==0 (state=IDLE).
- Outputs are Moore, decoded from state only:
  - key_out = 0 in PRESS, 1 otherwise.
  - busy = 1 in PRESS, RELEASE and DONE.
  - done = 1 only in DONE.
  - Reset values: key_out=1, busy=0, done=0.
- IDLE:
  - start=1 and press_count!=0: next state PRESS, timer<=PRESS_CYCLES-1, remaining<=press_count.
  - start=1 and press_count==0: next state DONE. No press is generated, but done still pulses.
  - start=0: stay in IDLE.
- PRESS:
  - timer!=0: timer decrements by 1.
  - timer==0: next state RELEASE, timer<=GAP_CYCLES-1, remaining<=remaining-1.
- RELEASE:
  - timer!=0: timer decrements by 1.
  - timer==0 and remaining!=0: next state PRESS, timer<=PRESS_CYCLES-1.
  - timer==0 and remaining==0: next state DONE.
- DONE: lasts exactly one cycle, then IDLE unconditionally.
- Latency: key_out falls on the first clock edge after the start sample.
  - Low for exactly PRESS_CYCLES cycles, then high for exactly GAP_CYCLES cycles, repeated per press.
  - done is asserted N*(PRESS_CYCLES+GAP_CYCLES)+1 cycles after the start sample edge, where N = press_count.
  - When press_count==0, done is asserted 1 cycle after the start sample edge.
- start while busy (PRESS, RELEASE or DONE): ignored, not queued.
- start in the same cycle as DONE: ignored. A new burst requires start in IDLE.
- press_count changing mid-burst has no effect; it is latched only at an accepted start.
- press_count=255: full 255 presses. remaining never wraps, because it is decremented only while !=0.
- Reset mid-burst: key_out returns to 1 immediately (asynchronously), busy/done go to 0, and the burst is abandoned. A downstream detector caught in its pressed state then sees a release.
- Illegal state encodings: none exist (all four codes are used). The default branch forces next state IDLE.

Decomposition:
- Shared package key_pkg: state encodings (IDLE/PRESS/RELEASE/DONE) and the KEY_ACTIVE=1'b0 constant. keypressed encodings may migrate there later.
- One natural sub-module, cycle_timer, parameterized TIMER_W. It provides load/value, a decrement enable, and a zero flag. Everything else stays in key_press_driver.

Test Plan:
- Reset check: hold reset=0, then release -> key_out=1, busy=0, done=0; no activity for 20 cycles with start=0.
- Single press (PRESS_CYCLES=4, GAP_CYCLES=4, press_count=1): start at edge 0 ->
  - key_out=0 in cycles 1-4, 1 in cycles 5-8.
  - done=1 in cycle 9 only.
  - busy=1 in cycles 1-9.
- Loopback into keypressed (press_count=3) -> exactly 3 enable_out pulses, each 1 cycle wide. done asserts at cycle 25.
- Zero count and ignored start: press_count=0 start -> done in cycle 1, key_out stays 1. A second start during an active burst of 2 -> burst length unchanged, total done pulses=1.
- Reset mid-burst: press_count=5, assert reset in the 2nd PRESS -> key_out=1 in the same cycle, busy=0. After release, IDLE persists until the next start.
- Max count: press_count=255 with PRESS_CYCLES=GAP_CYCLES=1 -> 255 low pulses. done at cycle 511. No wrap.
